acc_scheduler: RTL and testbench
================================

Name: acc_scheduler

Overview:
Job sequencer for the block-matching accelerator. It accepts a host byte stream and steers it into curr_mem (16x16 block, 256 B) and search_mem (32x32 window, 1024 B) with generated addresses. It then kicks the control unit and guards it with a watchdog. It latches the best-match result and holds it under a valid/ready handshake until the host takes it.

Parameters:
CURR_BYTES, 256, bytes loaded into curr_mem per job
SRCH_BYTES, 1024, bytes loaded into search_mem per job
TIMEOUT_CYCLES, 100000, max RUN cycles before abort (nominal search is 17*17*256 = 73984)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  begin job; sampled only in IDLE
mode_i  in  2  load mode latched at start: 00 full, 01 curr only, 10 search only, 11 no load
busy_o  out  1  state != IDLE
ld_valid_i  in  1  host byte valid
ld_ready_o  out  1  scheduler accepts byte
ld_data_i  in  8  host byte
curr_mem_we_o  out  1  curr_mem write strobe
curr_mem_waddr_o  out  8  curr_mem write address
curr_mem_wdata_o  out  8  curr_mem write data
search_mem_we_o  out  1  search_mem write strobe
search_mem_waddr_o  out  10  search_mem write address
search_mem_wdata_o  out  8  search_mem write data
cu_start_o  out  1  one-cycle kick to control unit
cu_done_i  in  1  one-cycle completion pulse from control unit
cu_sad_i  in  16  minimum SAD, valid with cu_done_i
cu_mv_x_i  in  5  best x offset 0..16, valid with cu_done_i
cu_mv_y_i  in  5  best y offset 0..16, valid with cu_done_i
res_valid_o  out  1  result available
res_ready_i  in  1  host consumes result
res_sad_o  out  16  latched SAD
res_mv_x_o  out  5  latched x offset
res_mv_y_o  out  5  latched y offset
res_err_o  out  1  1 = job aborted by watchdog

Behaviour:
- Reset: state IDLE. All outputs 0. Byte counter 0, watchdog 0. Memory contents are retained and not specified.
- States: IDLE, LOAD_CURR, LOAD_SRCH, FLUSH, RUN, RESULT.
- IDLE: on start_i, latch mode_i.
  - 00 and 01 go to LOAD_CURR.
  - 10 goes to LOAD_SRCH.
  - 11 goes to FLUSH.
- LOAD_*: ld_ready_o = 1. A handshake is ld_valid_i && ld_ready_o.
  - Each handshake increments a shared 10-bit counter.
  - The write is registered: we/addr/data appear exactly 1 cycle after the handshake, for 1 cycle. addr = counter value at the handshake.
  - Gaps in ld_valid_i stall the load with no timeout.
- LOAD_CURR: after handshake CURR_BYTES-1 (addr 255), clear the counter.
  - Mode 00 goes to LOAD_SRCH.
  - Mode 01 goes to FLUSH.
- LOAD_SRCH: after handshake SRCH_BYTES-1 (addr 1023), clear the counter and go to FLUSH.
- FLUSH: one cycle with ld_ready_o = 0. The final write strobe is presented here. Go to RUN.
- RUN:
  - cu_start_o = 1 on the first RUN cycle only, i.e. 2 cycles after the last handshake.
  - The watchdog counts RUN cycles.
  - On cu_done_i: latch sad/mv, set res_err_o = 0, go to RESULT.
  - On watchdog = TIMEOUT_CYCLES-1 without done: set sad = 16'hFFFF, mv = 0, res_err_o = 1, go to RESULT.
  - If done and expiry coincide, done wins.
- RESULT: res_valid_o = 1, outputs stable. On res_ready_i, clear res_valid_o and go to IDLE.
- res_sad_o, res_mv_*_o and res_err_o hold their last values after handshake until the next latch.
- Ignored inputs:
  - start_i outside IDLE, including the cycle of the result handshake.
  - cu_done_i outside RUN.
  - ld_valid_i outside LOAD_*.
- Reset asserted in any state: return to IDLE on the next edge.
  - Any pending write strobe is dropped.
  - res_valid_o, res_err_o and cu_start_o are cleared.
- Width rules:
  - Counter is 10 bits; curr address uses the low 8 bits.
  - Watchdog width is $clog2(TIMEOUT_CYCLES).
  - SAD max is 256*255 = 65280, so it never collides with the 16'hFFFF abort value.

Decomposition:
- acc_pkg:
  - sched_state_e
  - ld_mode_e (LD_FULL, LD_CURR, LD_SRCH, LD_NONE)
  - CURR_BYTES / SRCH_BYTES localparams
  - SAD_W = 16, MV_W = 5
  - me_result_t struct {sad, mv_x, mv_y, err}
- Sub-module acc_watchdog: clear/enable/expire counter parameterised by TIMEOUT_CYCLES.
- Everything else lives in acc_scheduler.

Test Plan:
- Full load: mode 00, stream bytes i&8'hFF for 1280 handshakes.
  - curr writes addr 0..255, then search writes addr 0..1023, each 1 cycle after its handshake.
  - cu_start_o 2 cycles after the last handshake.
  - cu_done_i with sad=1234, mv=(7,9) gives res_valid_o=1, sad=1234, mv=(7,9), err=0.
- Mode 01: 256 bytes, then only curr strobes. search_mem_we_o never asserts and cu_start_o follows.
- Mode 11: start_i gives cu_start_o 2 cycles later with zero writes.
- Backpressure: ld_valid_i toggling 1-0-0-1.
  - Addresses stay contiguous with no duplicates.
  - res_ready_i held low for 10 cycles keeps the result stable.
  - start_i pulsed during RESULT is ignored.
- Timeout: TIMEOUT_CYCLES=50 and no cu_done_i gives RESULT on RUN cycle 50 with err=1 and sad=16'hFFFF.
  - Separately, done on the expiry cycle gives err=0.
- Reset mid-load: rst_i at handshake 100 of LOAD_SRCH.
  - Next cycle: IDLE, no write strobe, busy_o=0.
  - A new mode 10 job restarts at search addr 0.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared constants and types for the block-matching job scheduler.
//   CURR_BYTES / SRCH_BYTES : bytes streamed into curr_mem / search_mem per job
//   CNT_W                   : width of the shared load byte counter
//   SAD_W / MV_W            : result field widths
//   sched_state_e           : scheduler FSM states
//   ld_mode_e               : load mode latched at job start
//   me_result_t             : latched best-match result
package acc_pkg;

    localparam int unsigned CURR_BYTES = 256;
    localparam int unsigned SRCH_BYTES = 1024;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned SAD_W      = 16;
    localparam int unsigned MV_W       = 5;

    // Largest real SAD is 256*255 = 65280, so all-ones is free to flag an abort.
    localparam logic [SAD_W-1:0] SAD_ABORT = 16'hFFFF;
    localparam logic [CNT_W-1:0] CURR_LAST = CNT_W'(CURR_BYTES - 1);
    localparam logic [CNT_W-1:0] SRCH_LAST = CNT_W'(SRCH_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadCurr,
        StLoadSrch,
        StFlush,
        StRun,
        StResult
    } sched_state_e;

    typedef enum logic [1:0] {
        LD_FULL = 2'b00,
        LD_CURR = 2'b01,
        LD_SRCH = 2'b10,
        LD_NONE = 2'b11
    } ld_mode_e;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [MV_W-1:0]  mv_x;
        logic [MV_W-1:0]  mv_y;
        logic             err;
    } me_result_t;

endpackage

// File: rtl/acc_watchdog.sv
// acc_watchdog: cycle counter that flags expiry on its TIMEOUT_CYCLES-th enabled cycle.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clr_i    : synchronous clear (dominates enable)
//   en_i     : count this cycle
//   expire_o : high while enabled and the count equals TIMEOUT_CYCLES-1
module acc_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire_o = en_i && (r_cnt == LIMIT);

endmodule

// File: rtl/acc_scheduler.sv
// acc_scheduler: job sequencer for the block-matching accelerator.
//   start_i/mode_i          : begin a job and choose which memories to load
//   busy_o                  : scheduler not idle
//   ld_valid_i/ld_ready_o/ld_data_i : host byte stream
//   curr_mem_* / search_mem_*       : registered write ports, one cycle after each byte
//   cu_start_o              : one-cycle kick on the first RUN cycle
//   cu_done_i, cu_sad_i, cu_mv_*_i  : completion and result from the control unit
//   res_valid_o/res_ready_i : result handshake; res_* hold until the next job latches
module acc_scheduler
    import acc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    output logic             busy_o,
    input  logic             ld_valid_i,
    output logic             ld_ready_o,
    input  logic [7:0]       ld_data_i,
    output logic             curr_mem_we_o,
    output logic [7:0]       curr_mem_waddr_o,
    output logic [7:0]       curr_mem_wdata_o,
    output logic             search_mem_we_o,
    output logic [9:0]       search_mem_waddr_o,
    output logic [7:0]       search_mem_wdata_o,
    output logic             cu_start_o,
    input  logic             cu_done_i,
    input  logic [SAD_W-1:0] cu_sad_i,
    input  logic [MV_W-1:0]  cu_mv_x_i,
    input  logic [MV_W-1:0]  cu_mv_y_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [SAD_W-1:0] res_sad_o,
    output logic [MV_W-1:0]  res_mv_x_o,
    output logic [MV_W-1:0]  res_mv_y_o,
    output logic             res_err_o
);

    sched_state_e     r_state;
    sched_state_e     w_state_next;
    ld_mode_e         r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hs;
    logic             w_last_byte;
    logic             w_run;
    logic             w_expire;

    logic             r_curr_we;
    logic [7:0]       r_curr_waddr;
    logic [7:0]       r_curr_wdata;
    logic             r_srch_we;
    logic [9:0]       r_srch_waddr;
    logic [7:0]       r_srch_wdata;
    logic             r_cu_start;
    me_result_t       r_res;

    assign ld_ready_o  = (r_state == StLoadCurr) || (r_state == StLoadSrch);
    assign w_hs        = ld_valid_i && ld_ready_o;
    assign w_last_byte = ((r_state == StLoadCurr) && (r_cnt == CURR_LAST)) ||
                         ((r_state == StLoadSrch) && (r_cnt == SRCH_LAST));
    assign w_run       = (r_state == StRun);

    acc_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (!w_run),
        .en_i     (w_run),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    unique case (ld_mode_e'(mode_i))
                        LD_FULL, LD_CURR: w_state_next = StLoadCurr;
                        LD_SRCH:          w_state_next = StLoadSrch;
                        LD_NONE:          w_state_next = StFlush;
                    endcase
                end
            end
            StLoadCurr: begin
                if (w_hs && w_last_byte) begin
                    w_state_next = (r_mode == LD_FULL) ? StLoadSrch : StFlush;
                end
            end
            StLoadSrch: begin
                if (w_hs && w_last_byte) begin
                    w_state_next = StFlush;
                end
            end
            StFlush:  w_state_next = StRun;
            StRun: begin
                if (cu_done_i || w_expire) begin
                    w_state_next = StResult;
                end
            end
            StResult: begin
                if (res_ready_i) begin
                    w_state_next = StIdle;
                end
            end
            default:  w_state_next = StIdle;
        endcase
    end

    // Load datapath: shared byte counter and one-cycle-delayed write ports.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode       <= LD_FULL;
            r_cnt        <= '0;
            r_curr_we    <= 1'b0;
            r_curr_waddr <= '0;
            r_curr_wdata <= '0;
            r_srch_we    <= 1'b0;
            r_srch_waddr <= '0;
            r_srch_wdata <= '0;
        end else begin
            if ((r_state == StIdle) && start_i) begin
                r_mode <= ld_mode_e'(mode_i);
            end
            r_curr_we <= w_hs && (r_state == StLoadCurr);
            r_srch_we <= w_hs && (r_state == StLoadSrch);
            if (w_hs) begin
                r_cnt <= w_last_byte ? '0 : r_cnt + 1'b1;
                if (r_state == StLoadCurr) begin
                    r_curr_waddr <= r_cnt[7:0];
                    r_curr_wdata <= ld_data_i;
                end else begin
                    r_srch_waddr <= r_cnt;
                    r_srch_wdata <= ld_data_i;
                end
            end
        end
    end

    // FLUSH always precedes RUN, so registering "in FLUSH" yields the first-RUN-cycle kick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cu_start <= 1'b0;
            r_res      <= '0;
        end else begin
            r_cu_start <= (r_state == StFlush);
            if (w_run) begin
                if (cu_done_i) begin
                    r_res.sad  <= cu_sad_i;
                    r_res.mv_x <= cu_mv_x_i;
                    r_res.mv_y <= cu_mv_y_i;
                    r_res.err  <= 1'b0;
                end else if (w_expire) begin
                    r_res.sad  <= SAD_ABORT;
                    r_res.mv_x <= '0;
                    r_res.mv_y <= '0;
                    r_res.err  <= 1'b1;
                end
            end
        end
    end

    assign busy_o             = (r_state != StIdle);
    assign curr_mem_we_o      = r_curr_we;
    assign curr_mem_waddr_o   = r_curr_waddr;
    assign curr_mem_wdata_o   = r_curr_wdata;
    assign search_mem_we_o    = r_srch_we;
    assign search_mem_waddr_o = r_srch_waddr;
    assign search_mem_wdata_o = r_srch_wdata;
    assign cu_start_o         = r_cu_start;
    assign res_valid_o        = (r_state == StResult);
    assign res_sad_o          = r_res.sad;
    assign res_mv_x_o         = r_res.mv_x;
    assign res_mv_y_o         = r_res.mv_y;
    assign res_err_o          = r_res.err;

endmodule

// File: tb/tb_acc_scheduler.sv
// tb_acc_scheduler: self-checking bench for acc_scheduler with a short watchdog.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_acc_scheduler;

    localparam int unsigned TO = 50;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  mode_i;
    logic        busy_o;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [7:0]  ld_data_i;
    logic        curr_mem_we_o;
    logic [7:0]  curr_mem_waddr_o;
    logic [7:0]  curr_mem_wdata_o;
    logic        search_mem_we_o;
    logic [9:0]  search_mem_waddr_o;
    logic [7:0]  search_mem_wdata_o;
    logic        cu_start_o;
    logic        cu_done_i;
    logic [15:0] cu_sad_i;
    logic [4:0]  cu_mv_x_i;
    logic [4:0]  cu_mv_y_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [15:0] res_sad_o;
    logic [4:0]  res_mv_x_o;
    logic [4:0]  res_mv_y_o;
    logic        res_err_o;

    always #5 clk_i = ~clk_i;

    acc_scheduler #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .mode_i             (mode_i),
        .busy_o             (busy_o),
        .ld_valid_i         (ld_valid_i),
        .ld_ready_o         (ld_ready_o),
        .ld_data_i          (ld_data_i),
        .curr_mem_we_o      (curr_mem_we_o),
        .curr_mem_waddr_o   (curr_mem_waddr_o),
        .curr_mem_wdata_o   (curr_mem_wdata_o),
        .search_mem_we_o    (search_mem_we_o),
        .search_mem_waddr_o (search_mem_waddr_o),
        .search_mem_wdata_o (search_mem_wdata_o),
        .cu_start_o         (cu_start_o),
        .cu_done_i          (cu_done_i),
        .cu_sad_i           (cu_sad_i),
        .cu_mv_x_i          (cu_mv_x_i),
        .cu_mv_y_i          (cu_mv_y_i),
        .res_valid_o        (res_valid_o),
        .res_ready_i        (res_ready_i),
        .res_sad_o          (res_sad_o),
        .res_mv_x_o         (res_mv_x_o),
        .res_mv_y_o         (res_mv_y_o),
        .res_err_o          (res_err_o)
    );

    typedef struct {
        bit srch;
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        logic [15:0] sad;
        logic [4:0]  x;
        logic [4:0]  y;
        logic        err;
        int          cyc;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Advance one cycle and check write strobes against the write scoreboard.
    task automatic step();
        wr_t e;
        int  got_addr;
        int  got_data;
        @(posedge clk_i);
        #1;
        cyc++;
        if (curr_mem_we_o === 1'b1 || search_mem_we_o === 1'b1) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: cyc %0d curr_we %0b srch_we %0b, required no strobe",
                         cyc, curr_mem_we_o, search_mem_we_o);
            end else begin
                e        = wr_q.pop_front();
                got_addr = search_mem_we_o ? int'(search_mem_waddr_o) : int'(curr_mem_waddr_o);
                got_data = search_mem_we_o ? int'(search_mem_wdata_o) : int'(curr_mem_wdata_o);
                if ((curr_mem_we_o === 1'b1 && search_mem_we_o === 1'b1) ||
                    (bit'(search_mem_we_o) != e.srch) || got_addr != e.addr ||
                    got_data != e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL wr_match: got cyc %0d srch %0b addr %0d data %0d, required cyc %0d srch %0b addr %0d data %0d",
                             cyc, search_mem_we_o, got_addr, got_data, e.cyc, e.srch, e.addr, e.data);
                end
            end
        end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
            n_cmp++;
            n_fail++;
            e = wr_q.pop_front();
            $display("FAIL wr_missing: cyc %0d no strobe, required srch %0b addr %0d at cyc %0d",
                     cyc, e.srch, e.addr, e.cyc);
        end
    endtask

    task automatic start_job(input logic [1:0] mode, output int k);
        mode_i  = mode;
        start_i = 1'b1;
        k       = cyc;
        step();
        start_i = 1'b0;
        mode_i  = 2'b00;
    endtask

    // Stream n_curr + n_srch bytes (value = index & 0xFF) with 'gap' idle cycles after each.
    task automatic drive_load(input int n_curr, input int n_srch, input int gap, output int last_hs);
        wr_t e;
        int  i;
        int  guard;
        int  total;
        i       = 0;
        guard   = 0;
        total   = n_curr + n_srch;
        last_hs = cyc;
        while (i < total) begin
            ld_valid_i = 1'b1;
            ld_data_i  = 8'(i);
            if (ld_ready_o === 1'b1) begin
                e.srch  = (i >= n_curr);
                e.addr  = e.srch ? i - n_curr : i;
                e.data  = i & 255;
                e.cyc   = cyc + 1;
                wr_q.push_back(e);
                last_hs = cyc;
                i++;
                guard   = 0;
                step();
                if (gap > 0 && i < total) begin
                    ld_valid_i = 1'b0;
                    ld_data_i  = 8'hEE;
                    repeat (gap) step();
                end
            end else begin
                guard++;
                if (guard > 8) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL ld_ready_timeout: byte %0d ld_ready_o %0b, required 1", i, ld_ready_o);
                    i = total;
                end else begin
                    step();
                end
            end
        end
        ld_valid_i = 1'b0;
    endtask

    task automatic wait_cu_start(input int exp_cyc);
        int guard;
        guard = 0;
        while (cu_start_o !== 1'b1 && guard < 3000) begin
            step();
            guard++;
        end
        n_cmp++;
        if (cu_start_o !== 1'b1 || cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL cu_start_time: got %0b at cyc %0d, required 1 at cyc %0d",
                     cu_start_o, cyc, exp_cyc);
        end
        step();
        n_cmp++;
        if (cu_start_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cu_start_width: got %0b, required 0", cu_start_o);
        end
    endtask

    task automatic pulse_done(input logic [15:0] sad, input logic [4:0] x, input logic [4:0] y);
        res_t r;
        cu_done_i = 1'b1;
        cu_sad_i  = sad;
        cu_mv_x_i = x;
        cu_mv_y_i = y;
        r.sad     = sad;
        r.x       = x;
        r.y       = y;
        r.err     = 1'b0;
        r.cyc     = cyc + 1;
        res_q.push_back(r);
        step();
        cu_done_i = 1'b0;
        cu_sad_i  = 16'h5A5A;
        cu_mv_x_i = 5'd3;
        cu_mv_y_i = 5'd4;
    endtask

    // Wait for the result, hold ready low 'hold' cycles, then take it.
    task automatic take_result(input int hold, input bit poke_start);
        res_t e;
        int   guard;
        guard = 0;
        if (res_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL res_queue: empty, required an expected result");
            return;
        end
        e = res_q.pop_front();
        while (res_valid_o !== 1'b1 && guard < 200) begin
            step();
            guard++;
        end
        n_cmp++;
        if (res_valid_o !== 1'b1 || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL res_time: valid %0b at cyc %0d, required 1 at cyc %0d", res_valid_o, cyc, e.cyc);
        end
        n_cmp++;
        if (res_sad_o !== e.sad || res_mv_x_o !== e.x || res_mv_y_o !== e.y || res_err_o !== e.err) begin
            n_fail++;
            $display("FAIL res_value: got sad %0d mv (%0d,%0d) err %0b, required sad %0d mv (%0d,%0d) err %0b",
                     res_sad_o, res_mv_x_o, res_mv_y_o, res_err_o, e.sad, e.x, e.y, e.err);
        end
        for (int h = 0; h < hold; h++) begin
            start_i = poke_start && (h == 3);
            step();
            start_i = 1'b0;
            n_cmp++;
            if (res_valid_o !== 1'b1 || res_sad_o !== e.sad || res_mv_x_o !== e.x ||
                res_mv_y_o !== e.y || res_err_o !== e.err) begin
                n_fail++;
                $display("FAIL res_hold: cycle %0d valid %0b sad %0d err %0b, required valid 1 sad %0d err %0b",
                         h, res_valid_o, res_sad_o, res_err_o, e.sad, e.err);
            end
        end
        res_ready_i = 1'b1;
        start_i     = poke_start;
        step();
        res_ready_i = 1'b0;
        start_i     = 1'b0;
        n_cmp++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL res_release: valid %0b busy %0b, required 0 0", res_valid_o, busy_o);
        end
        n_cmp++;
        if (res_sad_o !== e.sad || res_mv_x_o !== e.x || res_mv_y_o !== e.y || res_err_o !== e.err) begin
            n_fail++;
            $display("FAIL res_keep: sad %0d err %0b, required sad %0d err %0b",
                     res_sad_o, res_err_o, e.sad, e.err);
        end
        if (poke_start) begin
            step();
            n_cmp++;
            if (busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL start_ignored: busy %0b, required 0", busy_o);
            end
        end
    endtask

    task automatic check_wr_drained(input string name);
        n_cmp++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d writes pending, required 0", name, wr_q.size());
            wr_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        start_i     = 1'b0;
        mode_i      = 2'b00;
        ld_valid_i  = 1'b0;
        ld_data_i   = 8'h00;
        cu_done_i   = 1'b0;
        cu_sad_i    = 16'h0;
        cu_mv_x_i   = 5'd0;
        cu_mv_y_i   = 5'd0;
        res_ready_i = 1'b0;
        step();
        step();
        n_cmp++;
        if (busy_o !== 1'b0 || ld_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy %0b ready %0b, required 0 0", busy_o, ld_ready_o);
        end
        n_cmp++;
        if (cu_start_o !== 1'b0 || res_valid_o !== 1'b0 || res_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: cu_start %0b valid %0b err %0b, required 0 0 0",
                     cu_start_o, res_valid_o, res_err_o);
        end
        n_cmp++;
        if (res_sad_o !== 16'd0 || res_mv_x_o !== 5'd0 || res_mv_y_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_result: sad %0d mv (%0d,%0d), required 0 (0,0)",
                     res_sad_o, res_mv_x_o, res_mv_y_o);
        end
        n_cmp++;
        if (curr_mem_we_o !== 1'b0 || search_mem_we_o !== 1'b0 || curr_mem_waddr_o !== 8'd0 ||
            search_mem_waddr_o !== 10'd0 || curr_mem_wdata_o !== 8'd0 || search_mem_wdata_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_wr: curr_we %0b srch_we %0b, required all write outputs 0",
                     curr_mem_we_o, search_mem_we_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_full_load();
        int k;
        int last;
        start_job(2'b00, k);
        drive_load(256, 1024, 0, last);
        wait_cu_start(last + 2);
        repeat (3) step();
        pulse_done(16'd1234, 5'd7, 5'd9);
        take_result(0, 1'b0);
        check_wr_drained("full");
    endtask

    task automatic test_curr_only();
        int k;
        int last;
        start_job(2'b01, k);
        drive_load(256, 0, 0, last);
        wait_cu_start(last + 2);
        pulse_done(16'd500, 5'd16, 5'd0);
        take_result(0, 1'b0);
        check_wr_drained("curr_only");
    endtask

    task automatic test_no_load();
        int k;
        start_job(2'b11, k);
        n_cmp++;
        if (ld_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: ready %0b busy %0b, required 0 1", ld_ready_o, busy_o);
        end
        wait_cu_start(k + 2);
        pulse_done(16'd65280, 5'd16, 5'd16);
        take_result(0, 1'b0);
        check_wr_drained("no_load");
    endtask

    task automatic test_backpressure();
        int k;
        int last;
        start_job(2'b00, k);
        drive_load(256, 1024, 2, last);
        wait_cu_start(last + 2);
        pulse_done(16'd42, 5'd3, 5'd12);
        take_result(10, 1'b1);
        check_wr_drained("backpressure");
    endtask

    task automatic test_reset_mid_load();
        int k;
        int last;
        start_job(2'b10, k);
        drive_load(0, 100, 0, last);
        rst_i      = 1'b1;
        ld_valid_i = 1'b1;
        ld_data_i  = 8'hAB;
        step();
        rst_i      = 1'b0;
        ld_valid_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0 || ld_ready_o !== 1'b0 || curr_mem_we_o !== 1'b0 ||
            search_mem_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy %0b ready %0b curr_we %0b srch_we %0b, required 0 0 0 0",
                     busy_o, ld_ready_o, curr_mem_we_o, search_mem_we_o);
        end
        check_wr_drained("mid_reset");
    endtask

    // Mode 10 job after the mid-load reset: addresses restart at 0, then watchdog abort.
    task automatic test_timeout();
        int   k;
        int   last;
        res_t r;
        start_job(2'b10, k);
        drive_load(0, 1024, 0, last);
        wait_cu_start(last + 2);
        r.sad = 16'hFFFF;
        r.x   = 5'd0;
        r.y   = 5'd0;
        r.err = 1'b1;
        r.cyc = last + 2 + TO;
        res_q.push_back(r);
        take_result(2, 1'b0);
        check_wr_drained("timeout");
    endtask

    task automatic test_done_on_expiry();
        int k;
        int s;
        start_job(2'b11, k);
        s = k + 2;
        wait_cu_start(s);
        while (cyc < s + TO - 1) step();
        pulse_done(16'd777, 5'd1, 5'd2);
        take_result(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_curr_only();
        test_no_load();
        test_backpressure();
        test_reset_mid_load();
        test_timeout();
        test_done_on_expiry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
